// File: rtl/if_stage_pkg.sv
// Shared core definitions for the fetch and decode stages: bubble encoding,
// reset vector, fetch FSM encoding and the IF/ID bus layout.
package if_stage_pkg;

    localparam int          IF_ID_W      = 64;
    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0033;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_DROP = 2'd3;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } if_id_t;

endpackage

// File: rtl/if_stage_fetch_buf.sv
// Two-entry FIFO holding fetched {inst, pc} words between memory and decode.
// Flush wins over a same-cycle push or pop; callers only pop when non-empty.
module fetch_buf
    import if_stage_pkg::*;
#(
    parameter int W = IF_ID_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    input  logic         flush,
    output logic         full,
    output logic         empty,
    output logic [1:0]   count,
    output logic [W-1:0] head
);

    logic [W-1:0] mem [2];
    logic         rd_ptr;
    logic         wr_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

    assign full  = (count == 2'd2);
    assign empty = (count == 2'd0);
    assign head  = mem[rd_ptr];

    // The fetch FSM never lets FIFO plus in-flight exceed two words.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && full && !flush));

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: one outstanding imem request at a time, a 2-entry
// buffer to decode, redirect flush with drop of any in-flight response.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall_flag,
    input  logic               br_jmp_flag,
    input  logic [31:0]        br_target,
    input  logic               trap_flag,
    input  logic [31:0]        trap_vector,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_rvalid,
    input  logic [31:0]        imem_rdata,
    output logic [IF_ID_W-1:0] if_id_bus_out,
    output logic [1:0]         dbg_state
);

    logic [1:0]         state, state_nxt;
    logic [31:0]        fetch_pc, fetch_pc_nxt;
    logic [31:0]        req_pc;
    logic [31:0]        last_pc;
    logic [31:0]        redir_pc;
    logic               redirect, outstanding;
    logic               push, pop, full, empty;
    logic [1:0]         occ, occ_nxt;
    logic [IF_ID_W-1:0] head;
    if_id_t             push_word;

    assign redirect    = trap_flag | br_jmp_flag;
    assign redir_pc    = trap_flag ? trap_vector : br_target;
    assign pop         = !empty && !stall_flag && !redirect;
    assign push        = (state == ST_WAIT) && imem_rvalid && !redirect;
    assign occ_nxt     = occ + {1'b0, push} - {1'b0, pop};
    assign push_word   = '{inst: imem_rdata, pc: req_pc};
    // A request issued in REQ this cycle is in flight even if we redirect now.
    assign outstanding = (state == ST_REQ) ||
                         (((state == ST_WAIT) || (state == ST_DROP)) && !imem_rvalid);

    fetch_buf #(.W(IF_ID_W)) u_fetch_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_word),
        .pop       (pop),
        .flush     (redirect),
        .full      (full),
        .empty     (empty),
        .count     (occ),
        .head      (head)
    );

    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        case (state)
            ST_IDLE: if (!full || pop) state_nxt = ST_REQ;
            ST_REQ: begin
                fetch_pc_nxt = fetch_pc + 32'd4;
                state_nxt    = ST_WAIT;
            end
            ST_WAIT: if (imem_rvalid) state_nxt = (occ_nxt < 2'd2) ? ST_REQ : ST_IDLE;
            ST_DROP: if (imem_rvalid) state_nxt = ST_REQ;
            default: state_nxt = ST_IDLE;
        endcase
        if (redirect) begin
            fetch_pc_nxt = redir_pc;
            state_nxt    = outstanding ? ST_DROP : ST_REQ;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
            last_pc  <= RESET_PC;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            if (state == ST_REQ) req_pc <= imem_addr;
            if (!empty) last_pc <= head[31:0];
        end
    end

    assign imem_req      = (state == ST_REQ);
    assign imem_addr     = {fetch_pc[31:2], 2'b00};
    assign if_id_bus_out = empty ? {NOP_INST, last_pc} : head;
    assign dbg_state     = state;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a behavioural instruction memory of
// configurable latency; expected bus/address values are hand-derived.
module tb_if_stage;
  import if_stage_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0033;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_flag = 1'b0;
  logic        br_jmp_flag = 1'b0;
  logic [31:0] br_target = 32'h0;
  logic        trap_flag = 1'b0;
  logic [31:0] trap_vector = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [63:0] if_id_bus_out;
  logic [1:0]  dbg_state;

  int n_tests = 0;
  int n_fail = 0;

  if_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_flag    (stall_flag),
    .br_jmp_flag   (br_jmp_flag),
    .br_target     (br_target),
    .trap_flag     (trap_flag),
    .trap_vector   (trap_vector),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .if_id_bus_out (if_id_bus_out),
    .dbg_state     (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // memory model: answers a request seen in cycle t during cycle t+mem_lat
  int          mem_lat = 1;
  bit          mem_pat = 1'b0;
  int          mem_cnt = 0;
  bit          mem_busy = 1'b0;
  logic [31:0] mem_addr_q = 32'h0;
  bit          req_seen = 1'b0;
  logic [31:0] addr_seen = 32'h0;
  int          flush_req = 0;
  int          flush_ack = 0;

  function automatic logic [31:0] mem_word(input bit pat, input logic [31:0] a);
    return pat ? (32'h0000_0013 | (a << 12)) : 32'h0000_0013;
  endfunction

  always @(negedge clk) begin
    req_seen  = imem_req;
    addr_seen = imem_addr;
  end

  always @(posedge clk) begin
    #1;
    imem_rvalid = 1'b0;
    if (flush_ack != flush_req) begin
      flush_ack = flush_req;
      mem_busy  = 1'b0;
    end else if (mem_busy) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(mem_pat, mem_addr_q);
        mem_busy    = 1'b0;
      end
    end
    if (req_seen) begin
      if (mem_lat == 1) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(mem_pat, addr_seen);
      end else begin
        mem_busy   = 1'b1;
        mem_cnt    = mem_lat - 1;
        mem_addr_q = addr_seen;
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // returns at the release point; the next step() lands in the first REQ cycle
  task automatic do_reset(input int lat, input bit pat);
    rst_n       = 1'b0;
    stall_flag  = 1'b0;
    br_jmp_flag = 1'b0;
    trap_flag   = 1'b0;
    mem_lat     = lat;
    mem_pat     = pat;
    flush_req++;
    steps(3);
    rst_n = 1'b1;
  endtask

  // scoreboard check
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    // reset values, then 1-cycle memory returning 0x13 everywhere
    do_reset(1, 1'b0);
    chk("rst_state", {62'h0, dbg_state}, {62'h0, ST_IDLE});
    chk("rst_req", {63'h0, imem_req}, 64'h0);
    chk("rst_addr", {32'h0, imem_addr}, 64'h0);
    chk("rst_bus", if_id_bus_out, {NOP, 32'h0});
    step();
    chk("t1_c1_req", {31'h0, imem_req, imem_addr}, {31'h0, 1'b1, 32'h0});
    chk("t1_c1_state", {62'h0, dbg_state}, {62'h0, ST_REQ});
    step();
    chk("t1_c2_req", {31'h0, imem_req, imem_addr}, {31'h0, 1'b0, 32'h4});
    chk("t1_c2_bus", if_id_bus_out, {NOP, 32'h0});
    step();
    chk("t1_c3_req", {31'h0, imem_req, imem_addr}, {31'h0, 1'b1, 32'h4});
    chk("t1_c3_bus", if_id_bus_out, {32'h0000_0013, 32'h0});
    step();
    chk("t1_c4_bus", if_id_bus_out, {NOP, 32'h0});
    step();
    chk("t1_c5_req", {31'h0, imem_req, imem_addr}, {31'h0, 1'b1, 32'h8});
    chk("t1_c5_bus", if_id_bus_out, {32'h0000_0013, 32'h4});

    // stall while the buffer fills and stays full
    do_reset(1, 1'b1);
    stall_flag = 1'b1;
    steps(3);
    chk("t2_c3_bus", if_id_bus_out, {32'h0000_0013, 32'h0});
    steps(2);
    for (int i = 0; i < 3; i++) begin
      chk("t2_stall_req", {63'h0, imem_req}, 64'h0);
      chk("t2_stall_bus", if_id_bus_out, {32'h0000_0013, 32'h0});
      chk("t2_stall_state", {62'h0, dbg_state}, {62'h0, ST_IDLE});
      if (i < 2) step();
    end
    stall_flag = 1'b0;
    step();
    chk("t2_rel_bus", if_id_bus_out, {32'h0000_4013, 32'h4});
    chk("t2_rel_req", {31'h0, imem_req, imem_addr}, {31'h0, 1'b1, 32'h8});
    step();
    chk("t2_drain_bus", if_id_bus_out, {NOP, 32'h4});

    // branch while the 0x8 request is outstanding, 3-cycle memory
    do_reset(3, 1'b1);
    steps(9);
    chk("t3_c9_req", {31'h0, imem_req, imem_addr}, {31'h0, 1'b1, 32'h8});
    chk("t3_c9_bus", if_id_bus_out, {32'h0000_4013, 32'h4});
    step();
    chk("t3_c10_state", {62'h0, dbg_state}, {62'h0, ST_WAIT});
    br_jmp_flag = 1'b1;
    br_target   = 32'h0000_0100;
    step();
    br_jmp_flag = 1'b0;
    chk("t3_c11_state", {62'h0, dbg_state}, {62'h0, ST_DROP});
    chk("t3_c11_req", {31'h0, imem_req, imem_addr}, {31'h0, 1'b0, 32'h100});
    step();
    chk("t3_c12_state", {62'h0, dbg_state}, {62'h0, ST_DROP});
    step();
    chk("t3_c13_req", {31'h0, imem_req, imem_addr}, {31'h0, 1'b1, 32'h100});
    chk("t3_c13_bus", if_id_bus_out, {NOP, 32'h4});
    steps(3);
    chk("t3_c16_bus", if_id_bus_out, {NOP, 32'h4});
    step();
    chk("t3_c17_bus", if_id_bus_out, {32'h0010_0013, 32'h100});

    // trap and branch together: trap vector wins
    do_reset(1, 1'b1);
    step();
    chk("t4_c1_req", {31'h0, imem_req, imem_addr}, {31'h0, 1'b1, 32'h0});
    trap_flag   = 1'b1;
    trap_vector = 32'h0000_0200;
    br_jmp_flag = 1'b1;
    br_target   = 32'h0000_0100;
    step();
    trap_flag   = 1'b0;
    br_jmp_flag = 1'b0;
    chk("t4_c2_state", {62'h0, dbg_state}, {62'h0, ST_DROP});
    chk("t4_c2_addr", {32'h0, imem_addr}, {32'h0, 32'h200});
    step();
    chk("t4_c3_req", {31'h0, imem_req, imem_addr}, {31'h0, 1'b1, 32'h200});
    step();
    chk("t4_c4_bus", if_id_bus_out, {NOP, 32'h0});
    step();
    chk("t4_c5_bus", if_id_bus_out, {32'h0020_0013, 32'h200});

    // redirect during stall with a full buffer
    do_reset(1, 1'b1);
    stall_flag = 1'b1;
    steps(5);
    chk("t5_full_bus", if_id_bus_out, {32'h0000_0013, 32'h0});
    br_jmp_flag = 1'b1;
    br_target   = 32'h0000_0040;
    step();
    br_jmp_flag = 1'b0;
    chk("t5_flush_bus", if_id_bus_out, {NOP, 32'h0});
    chk("t5_flush_req", {31'h0, imem_req, imem_addr}, {31'h0, 1'b1, 32'h40});
    steps(2);
    chk("t5_c8_bus", if_id_bus_out, {32'h0004_0013, 32'h40});
    chk("t5_c8_req", {31'h0, imem_req, imem_addr}, {31'h0, 1'b1, 32'h44});
    stall_flag = 1'b0;

    // address wrap from 0xFFFFFFFC
    do_reset(1, 1'b1);
    steps(2);
    br_jmp_flag = 1'b1;
    br_target   = 32'hFFFF_FFFC;
    step();
    br_jmp_flag = 1'b0;
    chk("t6_c3_req", {31'h0, imem_req, imem_addr}, {31'h0, 1'b1, 32'hFFFF_FFFC});
    chk("t6_c3_bus", if_id_bus_out, {NOP, 32'h0});
    steps(2);
    chk("t6_c5_req", {31'h0, imem_req, imem_addr}, {31'h0, 1'b1, 32'h0});
    chk("t6_c5_bus", if_id_bus_out, {32'hFFFF_C013, 32'hFFFF_FFFC});

    // reset pulse while waiting on the 0x4 response
    do_reset(3, 1'b1);
    steps(6);
    chk("t7_c6_state", {62'h0, dbg_state}, {62'h0, ST_WAIT});
    rst_n = 1'b0;
    #1;
    chk("t7_rst_state", {62'h0, dbg_state}, {62'h0, ST_IDLE});
    chk("t7_rst_req", {31'h0, imem_req, imem_addr}, {31'h0, 1'b0, 32'h0});
    chk("t7_rst_bus", if_id_bus_out, {NOP, 32'h0});
    step();
    rst_n = 1'b1;
    step();
    chk("t7_c8_req", {31'h0, imem_req, imem_addr}, {31'h0, 1'b1, 32'h0});
    step();
    chk("t7_c9_bus", if_id_bus_out, {NOP, 32'h0});
    chk("t7_c9_state", {62'h0, dbg_state}, {62'h0, ST_WAIT});
    steps(3);
    chk("t7_c12_bus", if_id_bus_out, {32'h0000_0013, 32'h0});

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
